// File: rtl/fp_mul_operand_issue.sv
// fp_mul_operand_issue: operand issue FIFO ahead of the combinational FP multiplier
// Buffers operand pairs, pre-decodes IEEE special classes and tags each pair
// with a wrapping sequence number.
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_flush               synchronous discard of all buffered pairs
//   i_in_valid/o_in_ready input handshake, i_in_multiplicand/i_in_multiplier operands
//   o_out_valid/i_out_ready output handshake for the head pair
//   o_out_multiplicand/o_out_multiplier/o_out_class/o_out_tag head entry fields
//   o_level               current occupancy
// Optional (FP_ISSUE_STATS_EN): o_stat_special, o_stat_issued saturating pop counters.
module fp_mul_operand_issue #(
   parameter int MB    = 23,
   parameter int EB    = 8,
   parameter int DEPTH = 4,
   parameter int TAGW  = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_flush,
   input  logic                    i_in_valid,
   output logic                    o_in_ready,
   input  logic [EB+MB:0]          i_in_multiplicand,
   input  logic [EB+MB:0]          i_in_multiplier,
   output logic                    o_out_valid,
   input  logic                    i_out_ready,
   output logic [EB+MB:0]          o_out_multiplicand,
   output logic [EB+MB:0]          o_out_multiplier,
   output logic [3:0]              o_out_class,
   output logic [TAGW-1:0]         o_out_tag,
   output logic [$clog2(DEPTH):0]  o_level
`ifdef FP_ISSUE_STATS_EN
   ,
   output logic [15:0]             o_stat_special,
   output logic [15:0]             o_stat_issued
`endif
);
   localparam int W  = EB + MB + 1;
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [W-1:0]    r_opa [DEPTH];
   logic [W-1:0]    r_opb [DEPTH];
   logic [3:0]      r_cls [DEPTH];
   logic [TAGW-1:0] r_tag [DEPTH];
   logic [PW-1:0]   r_wp, r_rp;
   logic [LW-1:0]   r_level;
   logic [TAGW-1:0] r_tag_cnt;
   logic            w_push, w_pop;

   // {nan, inf, zero, denorm} for one operand, sign excluded
   function automatic logic [3:0] classify(input logic [W-2:0] f);
      logic e_max, e_zero, m_zero;
      e_max  = &f[W-2:MB];
      e_zero = ~|f[W-2:MB];
      m_zero = ~|f[MB-1:0];
      return {e_max & ~m_zero, e_max & m_zero, e_zero & m_zero, e_zero & ~m_zero};
   endfunction

   // in_ready deliberately ignores same-cycle pops to keep out_ready off this path
   assign o_in_ready         = i_rst_n && !i_flush && (r_level < LW'(DEPTH));
   assign o_out_valid        = r_level != '0;
   assign w_push             = i_in_valid && o_in_ready;
   assign w_pop              = o_out_valid && i_out_ready;
   assign o_out_multiplicand = r_opa[r_rp];
   assign o_out_multiplier   = r_opb[r_rp];
   assign o_out_class        = r_cls[r_rp];
   assign o_out_tag          = r_tag[r_rp];
   assign o_level            = r_level;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         // entries are cleared so the head reads as zero after reset
         for (int i = 0; i < DEPTH; i++) begin
            r_opa[i] <= '0;
            r_opb[i] <= '0;
            r_cls[i] <= '0;
            r_tag[i] <= '0;
         end
         r_wp      <= '0;
         r_rp      <= '0;
         r_level   <= '0;
         r_tag_cnt <= '0;
      end else if (i_flush) begin
         // tag counter keeps running across a flush
         r_wp    <= '0;
         r_rp    <= '0;
         r_level <= '0;
      end else begin
         if (w_push) begin
            r_opa[r_wp] <= i_in_multiplicand;
            r_opb[r_wp] <= i_in_multiplier;
            r_cls[r_wp] <= classify(i_in_multiplicand[W-2:0]) | classify(i_in_multiplier[W-2:0]);
            r_tag[r_wp] <= r_tag_cnt;
            r_wp        <= r_wp + PW'(1);
            r_tag_cnt   <= r_tag_cnt + TAGW'(1);
         end
         if (w_pop)
            r_rp <= r_rp + PW'(1);
         r_level <= r_level + LW'(w_push) - LW'(w_pop);
      end
   end

`ifdef FP_ISSUE_STATS_EN
   logic [15:0] r_stat_special, r_stat_issued;

   assign o_stat_special = r_stat_special;
   assign o_stat_issued  = r_stat_issued;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush) begin
         r_stat_special <= '0;
         r_stat_issued  <= '0;
      end else if (w_pop) begin
         r_stat_issued  <= r_stat_issued + 16'(r_stat_issued != 16'hFFFF);
         r_stat_special <= r_stat_special + 16'((o_out_class != 4'd0) && (r_stat_special != 16'hFFFF));
      end
   end
`endif

endmodule

// File: tb/tb_fp_mul_operand_issue.sv
// tb_fp_mul_operand_issue: scoreboard bench for fp_mul_operand_issue
module tb_fp_mul_operand_issue;
   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_a, in_b, out_a, out_b;
   logic [3:0]  out_class, out_tag;
   logic [2:0]  level;
`ifdef FP_ISSUE_STATS_EN
   logic [15:0] stat_special, stat_issued;
`endif

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  c;
      logic [3:0]  t;
   } exp_t;

   exp_t       q[$];
   logic [3:0] m_tag;
   int         n_pass = 0;
   int         n_total = 0;

   fp_mul_operand_issue #(.MB(23), .EB(8), .DEPTH(4), .TAGW(4)) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_flush(flush),
      .i_in_valid(in_valid),
      .o_in_ready(in_ready),
      .i_in_multiplicand(in_a),
      .i_in_multiplier(in_b),
      .o_out_valid(out_valid),
      .i_out_ready(out_ready),
      .o_out_multiplicand(out_a),
      .o_out_multiplier(out_b),
      .o_out_class(out_class),
      .o_out_tag(out_tag),
      .o_level(level)
`ifdef FP_ISSUE_STATS_EN
      ,
      .o_stat_special(stat_special),
      .o_stat_issued(stat_issued)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic logic [3:0] cls_of(input logic [31:0] f);
      logic [7:0]  e;
      logic [22:0] m;
      e = f[30:23];
      m = f[22:0];
      return {e == 8'hFF && m != 0, e == 8'hFF && m == 0, e == 8'h00 && m == 0, e == 8'h00 && m != 0};
   endfunction

   // scoreboard: handshakes resolve at the next rising edge
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         m_tag = 4'd0;
      end else if (flush) begin
         q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) check("pop_underflow", 1, 0);
            else begin
               exp_t e;
               e = q.pop_front();
               check("pop_a", out_a, e.a);
               check("pop_b", out_b, e.b);
               check("pop_class", out_class, e.c);
               check("pop_tag", out_tag, e.t);
            end
         end
         if (in_valid && in_ready) begin
            q.push_back('{a: in_a, b: in_b, c: cls_of(in_a) | cls_of(in_b), t: m_tag});
            m_tag = m_tag + 4'd1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      flush = 1'b0;
      #1 check("rst_in_ready", in_ready, 0);
      tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_level", level, 0);
      check("rst_out_a", out_a, 0);
      check("rst_out_b", out_b, 0);
      check("rst_class", out_class, 0);
      check("rst_tag", out_tag, 0);
`ifdef FP_ISSUE_STATS_EN
      check("rst_stat_special", stat_special, 0);
      check("rst_stat_issued", stat_issued, 0);
`endif
      rst_n = 1'b1;
      #1 check("post_rst_in_ready", in_ready, 1);
   endtask

   task automatic push1(input logic [31:0] a, input logic [31:0] b);
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 20 && out_valid; i++) tick();
      check("drain_empty", out_valid, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_a = '0;
      in_b = '0;
      tick();
      do_reset();

      // single pair latency and class decode
      out_ready = 1'b1;
      push1(32'h40A33333, 32'h3F800000);
      check("t1_valid", out_valid, 1);
      check("t1_a", out_a, 32'h40A33333);
      check("t1_class", out_class, 4'b0000);
      check("t1_tag", out_tag, 0);
      tick();
      check("t1_empty", out_valid, 0);
      push1(32'h00005555, 32'h7F800000);
      check("t2_class_inf_den", out_class, 4'b0101);
      tick();
      push1(32'h7FC00000, 32'h80000000);
      check("t2_class_nan_zero", out_class, 4'b1010);
      tick();

      // fill to full, single pop frees a slot one cycle later
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_a = 32'h3F800000 + k;
         in_b = 32'h40000000 + k;
         tick();
      end
      check("t3_full_ready", in_ready, 0);
      check("t3_full_level", level, 4);
      in_a = 32'h3F800004;
      in_b = 32'h40000004;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t3_ready_after_pop", in_ready, 1);
      check("t3_level_after_pop", level, 3);
      tick();
      in_valid = 1'b0;
      check("t3_level_refill", level, 4);
      drain();

      // streaming with tag wrap
      do_reset();
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         in_a = $urandom;
         in_b = (k % 5 == 0) ? 32'h7F800000 : $urandom;
         tick();
         check("t4_level", level, 1);
      end
      in_valid = 1'b0;
      tick();
      check("t4_level_end", level, 0);

      // flush keeps the tag counter running
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_a = 32'h41200000 + k;
         in_b = 32'h00000000;
         tick();
      end
      check("t5_level3", level, 3);
      flush = 1'b1;
      #1 check("t5_flush_ready", in_ready, 0);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      check("t5_level0", level, 0);
      check("t5_valid0", out_valid, 0);
      out_ready = 1'b1;
      push1(32'h3F000000, 32'h3E800000);
      check("t5_tag_after_flush", out_tag, 3);
      tick();

      // reset with contents held
      out_ready = 1'b0;
      push1(32'h11111111, 32'h22222222);
      push1(32'h33333333, 32'h44444444);
      check("t6_level2", level, 2);
      check("t6_valid", out_valid, 1);
      do_reset();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=0 exp=1");
      $fatal(1);
   end
endmodule
